// File: rtl/flattening_stream_buffer.sv
// flattening_stream_buffer
//   Collects the per-pixel outputs of NumOfImages conv channels into a
//   double-buffered frame store and streams the flattened frame (channel
//   major, element e = channel*Pixels + pix) as OutWidth-element beats.
//
// Ports
//   clk        rising-edge clock
//   res        synchronous active-high reset; discards all buffered data
//   in_valid   channel mask; lane k carries the channel of the k-th lowest set bit
//   in_data    NumOfInputs lanes of BitSize bits, lane 0 in the LSBs
//   in_ready   write side can accept this cycle
//   out_valid  a beat is available
//   out_ready  consumer accepts the beat
//   out_data   OutWidth elements, lane 0 = lowest element index
//   out_last   final beat of a frame
//   out_err    sticky protocol error (too many set mask bits, or a channel
//              written twice within one pixel)
//
// Handshake: a write is taken on a rising edge where in_valid != 0 and
// in_ready = 1; a beat is taken on a rising edge where out_valid = 1 and
// out_ready = 1. While out_valid = 1 and out_ready = 0, out_data and out_last
// hold their value. in_ready and out_valid depend only on registered state.
//
// The per-bank state (bank_state) is the FSM visible to checkers:
// EMPTY -> FILL -> FULL -> DRAIN -> EMPTY.
module flattening_stream_buffer #(
  parameter int BitSize     = 4,
  parameter int ImageSize   = 4,
  parameter int NumOfImages = 4,
  parameter int NumOfInputs = 2,
  parameter int OutWidth    = 4
) (
  input  logic                            clk,
  input  logic                            res,
  input  logic [NumOfImages-1:0]          in_valid,
  input  logic [NumOfInputs*BitSize-1:0]  in_data,
  output logic                            in_ready,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [OutWidth*BitSize-1:0]     out_data,
  output logic                            out_last,
  output logic                            out_err
);

  localparam int Pixels = ImageSize * ImageSize;
  localparam int Total  = NumOfImages * Pixels;
  localparam int Beats  = (Total + OutWidth - 1) / OutWidth;
  localparam int AW     = $clog2(2 * Total);
  localparam int PW     = $clog2(Pixels + 1);
  localparam int BW     = $clog2(Beats + 1);

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILL,
    BANK_FULL,
    BANK_DRAIN
  } bank_state_t;

  bank_state_t            bank_state [2];
  logic                   wr_bank;
  logic                   rd_bank;
  logic [PW-1:0]          pix;
  logic [NumOfImages-1:0] ch_mask;
  logic [BW-1:0]          beat;
  logic                   err_q;

  // Both banks live in one array: bank b occupies [b*Total, b*Total+Total).
  logic [BitSize-1:0]     mem [2*Total];

  logic [BitSize-1:0]     lane [NumOfInputs];
  logic [NumOfImages-1:0] wr_en;
  logic [BitSize-1:0]     wr_val [NumOfImages];
  logic                   lane_overflow;
  logic [NumOfImages-1:0] next_mask;
  logic                   accept;
  logic                   pixel_done;
  logic                   frame_done;
  logic                   beat_hs;

  always_comb begin
    for (int k = 0; k < NumOfInputs; k++) begin
      lane[k] = in_data[k*BitSize +: BitSize];
    end
  end

  // Lane routing: walk the mask from channel 0 upward, handing out lanes in
  // order. Set bits beyond the available lanes are dropped and flagged.
  always_comb begin
    int cnt;
    cnt           = 0;
    wr_en         = '0;
    lane_overflow = 1'b0;
    for (int c = 0; c < NumOfImages; c++) begin
      wr_val[c] = '0;
      if (in_valid[c]) begin
        if (cnt < NumOfInputs) begin
          wr_en[c] = 1'b1;
          for (int k = 0; k < NumOfInputs; k++) begin
            if (k == cnt) wr_val[c] = lane[k];
          end
        end else begin
          lane_overflow = 1'b1;
        end
        cnt++;
      end
    end
  end

  assign in_ready   = (bank_state[wr_bank] == BANK_EMPTY) ||
                      (bank_state[wr_bank] == BANK_FILL);
  assign accept     = (|in_valid) && in_ready;
  assign next_mask  = ch_mask | wr_en;
  assign pixel_done = accept && (&next_mask);
  assign frame_done = pixel_done && (pix == PW'(Pixels - 1));

  assign out_valid  = (bank_state[rd_bank] == BANK_FULL) ||
                      (bank_state[rd_bank] == BANK_DRAIN);
  assign beat_hs    = out_valid && out_ready;
  assign out_last   = out_valid && (beat == BW'(Beats - 1));
  assign out_err    = err_q;

  // Beat lanes past the end of the frame read as zero.
  always_comb begin
    out_data = '0;
    if (out_valid) begin
      for (int j = 0; j < OutWidth; j++) begin
        if (int'(beat) * OutWidth + j < Total) begin
          out_data[j*BitSize +: BitSize] =
            mem[AW'(int'(rd_bank) * Total + int'(beat) * OutWidth + j)];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!res && accept) begin
      for (int c = 0; c < NumOfImages; c++) begin
        if (wr_en[c]) begin
          mem[AW'(int'(wr_bank) * Total + c * Pixels + int'(pix))] <= wr_val[c];
        end
      end
    end
  end

  // Writer only touches a bank in EMPTY/FILL and the reader only in
  // FULL/DRAIN, so the two never update the same bank in one cycle even
  // when wr_bank == rd_bank.
  always_ff @(posedge clk) begin
    if (res) begin
      bank_state[0] <= BANK_EMPTY;
      bank_state[1] <= BANK_EMPTY;
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b0;
      pix           <= '0;
      ch_mask       <= '0;
      beat          <= '0;
      err_q         <= 1'b0;
    end else begin
      if (accept) begin
        if (bank_state[wr_bank] == BANK_EMPTY) bank_state[wr_bank] <= BANK_FILL;
        if (lane_overflow || (|(wr_en & ch_mask))) err_q <= 1'b1;
        if (pixel_done) begin
          ch_mask <= '0;
          if (frame_done) begin
            pix                 <= '0;
            bank_state[wr_bank] <= BANK_FULL;
            wr_bank             <= ~wr_bank;
          end else begin
            pix <= pix + 1'b1;
          end
        end else begin
          ch_mask <= next_mask;
        end
      end

      if (bank_state[rd_bank] == BANK_FULL) bank_state[rd_bank] <= BANK_DRAIN;
      if (beat_hs) begin
        if (out_last) begin
          beat                <= '0;
          bank_state[rd_bank] <= BANK_EMPTY;
          rd_bank             <= ~rd_bank;
        end else begin
          beat <= beat + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_flattening_stream_buffer.sv
module tb_flattening_stream_buffer;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        res = 1'b1;
  logic [3:0]  in_valid = '0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_last;
  logic        out_err;

  flattening_stream_buffer dut (
    .clk(clk), .res(res), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .out_err(out_err)
  );

  // 3x3 image, 3 channels: 27 elements -> 7 beats, last beat partly empty
  logic        res_b = 1'b1;
  logic [2:0]  in_valid_b = '0;
  logic [7:0]  in_data_b = '0;
  logic        in_ready_b;
  logic        out_valid_b;
  logic        out_ready_b = 1'b0;
  logic [15:0] out_data_b;
  logic        out_last_b;
  logic        out_err_b;

  flattening_stream_buffer #(.ImageSize(3), .NumOfImages(3)) dut_b (
    .clk(clk), .res(res_b), .in_valid(in_valid_b), .in_data(in_data_b),
    .in_ready(in_ready_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_data(out_data_b), .out_last(out_last_b), .out_err(out_err_b)
  );

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [16:0] exp_q[$];
  logic [16:0] got_q[$];
  int          hs_cyc_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output monitor: records every handshaken beat and checks that a
  // stalled beat is still presented unchanged on the next cycle.
  initial begin
    logic        stall_prev;
    logic [16:0] prev;
    stall_prev = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (res) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) check("stall_stable", {out_valid, out_last, out_data}, {1'b1, prev});
        if (out_valid && out_ready) begin
          got_q.push_back({out_last, out_data});
          hs_cyc_q.push_back(cyc);
        end
        stall_prev = out_valid && !out_ready;
        prev = {out_last, out_data};
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    res = 1'b1;
    tick();
    res = 1'b0;
  endtask

  task automatic wr(input logic [3:0] m, input logic [7:0] d);
    int n;
    in_valid = m;
    in_data = d;
    n = 0;
    while (!in_ready && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL wr_timeout: in_ready stayed 0, required 1");
    end
    tick();
    in_valid = '0;
  endtask

  function automatic logic [3:0] val(input int mode, input int c, input int p);
    case (mode)
      0:       return 4'(c + 1);
      1:       return 4'(p);
      2:       return 4'((p * 3 + c * 5 + 7) % 16);
      default: return 4'h0;
    endcase
  endfunction

  task automatic fill(input int mode, input int first, input int count);
    for (int p = first; p < first + count; p++) begin
      wr(4'b0011, {val(mode, 1, p), val(mode, 0, p)});
      wr(4'b1100, {val(mode, 3, p), val(mode, 2, p)});
    end
  endtask

  // Expected beats straight from e = channel*16 + pix, lane j = 4b + j.
  task automatic push_frame(input int mode);
    logic [15:0] d;
    int e;
    for (int b = 0; b < 16; b++) begin
      d = '0;
      for (int j = 0; j < 4; j++) begin
        e = b * 4 + j;
        d[j*4 +: 4] = val(mode, e / 16, e % 16);
      end
      exp_q.push_back({(b == 15), d});
    end
  endtask

  task automatic compare_q(input string name, input int bound);
    int n;
    int want;
    n = 0;
    want = exp_q.size();
    while (got_q.size() < want && n < bound) begin
      tick();
      n++;
    end
    repeat (3) tick();
    check({name, "_count"}, got_q.size(), want);
    while (exp_q.size() > 0 && got_q.size() > 0) check(name, got_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    got_q.delete();
  endtask

  // ---------------- vector tables ----------------
  typedef struct {
    logic [15:0] data;
    logic        last;
  } beat_vec_t;

  typedef struct {
    logic       rst;
    logic [3:0] mask;
    logic [7:0] data;
    logic       exp_err;
  } wr_vec_t;

  beat_vec_t beat_tab[16];
  wr_vec_t   wr_tab[13];

  initial begin
    logic [16:0] g;
    logic [16:0] bq[$];
    logic        hold_ok;
    logic [15:0] d;
    int          n;
    int          e;

    // Frame with channel c = c+1 everywhere: 4 beats per channel.
    for (int b = 0; b < 16; b++) begin
      case (b / 4)
        0:       beat_tab[b].data = 16'h1111;
        1:       beat_tab[b].data = 16'h2222;
        2:       beat_tab[b].data = 16'h3333;
        default: beat_tab[b].data = 16'h4444;
      endcase
      beat_tab[b].last = (b == 15);
    end

    // Error-flag sequence: overwrite, then (after reset) a 3-bit mask.
    wr_tab[0]  = '{1'b1, 4'b0000, 8'h00, 1'b0};
    wr_tab[1]  = '{1'b0, 4'b0001, 8'h07, 1'b0};
    wr_tab[2]  = '{1'b0, 4'b0001, 8'h03, 1'b1};
    wr_tab[3]  = '{1'b0, 4'b0110, 8'h21, 1'b1};
    wr_tab[4]  = '{1'b0, 4'b1000, 8'h04, 1'b1};
    wr_tab[5]  = '{1'b1, 4'b0000, 8'h00, 1'b0};
    wr_tab[6]  = '{1'b0, 4'b0111, 8'h65, 1'b1};
    wr_tab[7]  = '{1'b0, 4'b1000, 8'h0B, 1'b1};
    wr_tab[8]  = '{1'b0, 4'b0100, 8'h0A, 1'b1};
    wr_tab[9]  = '{1'b0, 4'b0001, 8'h07, 1'b1};
    wr_tab[10] = '{1'b0, 4'b0001, 8'h03, 1'b1};
    wr_tab[11] = '{1'b0, 4'b0110, 8'h00, 1'b1};
    wr_tab[12] = '{1'b0, 4'b1000, 8'h00, 1'b1};

    // ---- reset state ----
    do_reset();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_err", out_err, 0);

    // ---- frame of constant channels, free-running consumer ----
    out_ready = 1'b1;
    fill(0, 0, 15);
    wr(4'b0011, 8'h21);
    in_valid = 4'b1100;
    in_data = 8'h43;
    check("s1_ready_last_write", in_ready, 1);
    check("s1_valid_before_full", out_valid, 0);
    tick();
    in_valid = '0;
    check("s1_first_valid_latency", out_valid, 1);
    n = 0;
    while (got_q.size() < 16 && n < 100) begin
      tick();
      n++;
    end
    repeat (3) tick();
    check("s1_beat_count", got_q.size(), 16);
    for (int b = 0; b < 16 && got_q.size() > 0; b++) begin
      g = got_q.pop_front();
      check("s1_beat", g, {beat_tab[b].last, beat_tab[b].data});
    end
    got_q.delete();
    check("s1_out_err", out_err, 0);

    // ---- pixel-index frame, consumer toggling ready ----
    out_ready = 1'b0;
    fill(1, 0, 16);
    push_frame(1);
    n = 0;
    while (got_q.size() < 16 && n < 200) begin
      out_ready = ~out_ready;
      tick();
      n++;
    end
    out_ready = 1'b1;
    compare_q("s2_beat", 50);

    // ---- two frames back-to-back behind a stalled consumer ----
    out_ready = 1'b0;
    fill(0, 0, 16);
    fill(1, 0, 16);
    check("s3_in_ready_both_full", in_ready, 0);
    check("s3_out_valid_held", out_valid, 1);
    in_valid = 4'b0011;
    in_data = 8'hFF;
    hold_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (in_ready) hold_ok = 1'b0;
      tick();
    end
    in_valid = '0;
    check("s3_write_held_off", hold_ok, 1);
    push_frame(0);
    push_frame(1);
    hs_cyc_q.delete();
    out_ready = 1'b1;
    hold_ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (in_ready) hold_ok = 1'b0;
      tick();
    end
    check("s3_in_ready_low_during_drain", hold_ok, 1);
    check("s3_in_ready_rise", in_ready, 1);
    compare_q("s3_beat", 100);
    check("s3_hs_count", hs_cyc_q.size(), 32);
    if (hs_cyc_q.size() == 32) check("s3_no_gap", hs_cyc_q[31] - hs_cyc_q[0], 31);

    // ---- error flag: overwrite and too many mask bits ----
    for (int i = 0; i < 13; i++) begin
      if (wr_tab[i].rst) do_reset();
      else wr(wr_tab[i].mask, wr_tab[i].data);
      check($sformatf("s5_err_vec%0d", i), out_err, wr_tab[i].exp_err);
      check($sformatf("s5_ready_vec%0d", i), in_ready, 1);
    end
    fill(3, 2, 14);
    for (int b = 0; b < 16; b++) begin
      case (b)
        0:       d = 16'h0035;
        4:       d = 16'h0006;
        8:       d = 16'h000A;
        12:      d = 16'h000B;
        default: d = 16'h0000;
      endcase
      exp_q.push_back({(b == 15), d});
    end
    compare_q("s5_beat", 50);
    check("s5_err_sticky", out_err, 1);

    // ---- reset in the middle of a drain ----
    got_q.delete();
    fill(0, 0, 16);
    n = 0;
    while (got_q.size() < 5 && n < 100) begin
      tick();
      n++;
    end
    check("s6_reached_beat5", got_q.size(), 5);
    out_ready = 1'b0;
    res = 1'b1;
    tick();
    res = 1'b0;
    check("s6_out_valid", out_valid, 0);
    check("s6_in_ready", in_ready, 1);
    check("s6_out_err", out_err, 0);
    check("s6_out_data", out_data, 0);
    got_q.delete();
    out_ready = 1'b1;
    fill(2, 0, 16);
    push_frame(2);
    compare_q("s6_beat", 50);

    // ---- small configuration: 27 elements in 7 beats ----
    res_b = 1'b1;
    tick();
    res_b = 1'b0;
    out_ready_b = 1'b1;
    for (int p = 0; p < 9; p++) begin
      check("b_in_ready", in_ready_b, 1);
      in_valid_b = 3'b011;
      in_data_b = {4'(9 + p), 4'(p)};
      tick();
      in_valid_b = 3'b100;
      in_data_b = {4'h0, 4'((18 + p) % 16)};
      tick();
    end
    in_valid_b = '0;
    n = 0;
    while (bq.size() < 7 && n < 30) begin
      if (out_valid_b) bq.push_back({out_last_b, out_data_b});
      tick();
      n++;
    end
    check("b_beat_count", bq.size(), 7);
    for (int b = 0; b < 7 && bq.size() > 0; b++) begin
      d = '0;
      for (int j = 0; j < 4; j++) begin
        e = b * 4 + j;
        if (e < 27) d[j*4 +: 4] = 4'(e % 16);
      end
      check($sformatf("b_beat%0d", b), bq.pop_front(), {(b == 6), d});
    end
    check("b_beat6_literal_probe", {out_valid_b, out_last_b}, 2'b00);
    check("b_out_err", out_err_b, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/flattening_stream_buffer.md
Name: flattening_stream_buffer

Overview:
- Parametrised successor to the flattening layer: collects per-pixel outputs of NumOfImages conv channels into a double-buffered frame store.
- Inputs arrive on NumOfInputs shared lanes over several cycles per pixel; a per-channel valid mask routes each lane to its channel.
- Emits the flattened vector (channel-major) as OutWidth-element beats with valid/ready backpressure, so the dense layer can stall without losing data.

Parameters:
BitSize, 4, bits per element
ImageSize, 4, image edge; Pixels = ImageSize*ImageSize
NumOfImages, 4, channels per frame
NumOfInputs, 2, input lanes per cycle
OutWidth, 4, elements per output beat; Beats = ceil(NumOfImages*Pixels/OutWidth)

Ports:
clk  in  1  clock, all logic on rising edge
res  in  1  synchronous active-high reset
in_valid  in  NumOfImages  channel mask; lane k carries the channel of the k-th lowest set bit
in_data  in  NumOfInputs*BitSize  lane data, lane 0 in LSBs
in_ready  out  1  write side can accept this cycle
out_valid  out  1  beat available
out_ready  in  1  consumer accepts beat
out_data  out  OutWidth*BitSize  beat, lane 0 = lowest element index
out_last  out  1  final beat of a frame
out_err  out  1  sticky protocol error

Behaviour:
- Reset (any cycle, incl. mid-frame or mid-drain): both banks EMPTY, pixel counters 0, channel masks 0; in_ready=1, out_valid=0, out_last=0, out_data=0, out_err=0. Buffered data discarded.
- Bank state per bank: EMPTY -> FILL (first accepted write) -> FULL (last pixel complete) -> DRAIN (read side selects it) -> EMPTY (last beat handshaken). Write bank and read bank alternate 0,1,0,...
- Write accept when in_valid!=0 && in_ready. in_ready=1 iff current write bank is EMPTY or FILL.
- On accept: lane k writes element [channel][pix] for the k-th set bit; set bits beyond NumOfInputs are ignored and set out_err. Writing a channel already written for the current pixel overwrites and sets out_err.
- Pixel complete when the per-pixel channel mask (incl. this cycle's writes) is all ones: mask clears, pix increments. Pixel Pixels-1 complete -> bank FULL, write pointer toggles next cycle.
- Element index e = channel*Pixels + pix. Beat b lane j carries e = b*OutWidth + j; indices >= NumOfImages*Pixels drive 0.
- Read: out_valid=1 while read bank is FULL/DRAIN. First beat valid the cycle after the bank becomes FULL (1-cycle latency). Beat advances on out_valid && out_ready; out_data/out_last held stable while stalled. out_last=1 on beat Beats-1; its handshake frees the bank, and if the other bank is already FULL, out_valid stays 1 with its beat 0 next cycle (no bubble).
- Simultaneous: bank freed by drain in the same cycle the writer needs it -> in_ready rises the next cycle (registered). A write and a read never target the same bank.
- in_valid=0 cycles are idle; no timeout. out_err clears only on reset.

Test Plan:
- Defaults; channel c, all pixels value c+1; cycle pattern per pixel: mask 0011 then 1100, out_ready=1 -> 16 beats: beats 0-3 all 1, 4-7 all 2, 8-11 all 3, 12-15 all 4; out_last only on beat 15; first out_valid 1 cycle after 32nd write; out_err=0.
- Value = pix index (0..15) for every channel, out_ready toggled 1/0 each cycle -> beat b = {4b+3,4b+2,4b+1,4b} mod 16; data stable on stalled cycles; no beat lost or duplicated.
- Two frames back-to-back, out_ready=0 until both filled -> in_ready drops after frame 2 completes; frame-3 writes held off; with out_ready=1, 32 consecutive beats with no gap; in_ready rises 1 cycle after frame 1's last beat.
- ImageSize=3, OutWidth=4 (36 elements, 9 beats) and ImageSize=3, NumOfImages=3, OutWidth=4 (27 elements, 7 beats) -> beat 6 lanes 3 = 0, out_last on beat 6.
- Mask 0111 with NumOfInputs=2 -> channels 0,1 written, out_err=1 next cycle, pixel not complete; mask 0001 twice in same pixel -> second value stored, out_err=1.
- Assert res for one cycle mid-drain (beat 5) -> next cycle out_valid=0, in_ready=1, out_err=0; fresh frame then drains correctly from beat 0.
